pam_requester: RTL and testbench

//  Command sequencer (initiator) driving the page allocation map's strobe/done port.
//  - Accepts one CPU-side command at a time: bulk alloc N, bulk free N, free-all, stat/set/clear.
//  - Issues single-page PAM operations back to back.
//  - Buffers returned page numbers in a result FIFO.
//  - Reports completion count and error status.

---
 rtl/pam_pkg.sv | 44 ++++
 rtl/pam_req_fifo.sv | 59 +++++
 rtl/pam_requester.sv | 222 ++++++++++++++++++++++
 tb/tb_pam_requester.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pam_pkg.sv
// Shared types and constants for the PAM command sequencer.
package pam_pkg;

  localparam int unsigned PGW_DEF      = 15;
  localparam int unsigned CNTW_DEF     = 8;
  localparam int unsigned FIFO_LOG_DEF = 4;
  localparam int unsigned TIMEOUT_DEF  = 1023;

  typedef enum logic [2:0] {
    ALLOC_N = 3'd0,
    FREE_N  = 3'd1,
    FREEALL = 3'd2,
    STAT    = 3'd3,
    SET     = 3'd4,
    CLR     = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    ST_WAITRDY,
    ST_IDLE,
    ST_ISSUE,
    ST_ACCEPT,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OOM = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  localparam logic [1:0] VAL_READ = 2'b10;
  localparam logic [1:0] VAL_CLR  = 2'b00;
  localparam logic [1:0] VAL_SET  = 2'b01;

  // One-cycle strobes toward the PAM; at most one bit set at a time.
  typedef struct packed {
    logic alloc;
    logic free;
    logic freeall;
    logic stat;
  } pam_strb_t;

endpackage

// File: rtl/pam_req_fifo.sv
// Synchronous result FIFO with count-based, registered full/empty flags.
module pam_req_fifo #(
  parameter int unsigned W   = 15,
  parameter int unsigned LOG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic         empty,
  output logic         full
);

  localparam int unsigned DEPTH = 1 << LOG;
  localparam int unsigned CW    = LOG + 1;

  logic [W-1:0]   mem [DEPTH];
  logic [LOG-1:0] wptr, rptr;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           do_push, do_pop;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && !full;
    cnt_nxt = cnt + CW'(do_push) - CW'(do_pop);
    if (flush) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CW'(DEPTH));
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) begin
          mem[wptr] <= wdat;
          wptr      <= wptr + LOG'(1);
        end
        if (do_pop) rptr <= rptr + LOG'(1);
      end
    end
  end

  assign rdat = mem[rptr];

endmodule

// File: rtl/pam_requester.sv
// Command sequencer driving the page allocation map strobe/done port,
// issuing single-page operations back to back and buffering allocated pages.
module pam_requester
  import pam_pkg::*;
#(
  parameter int unsigned PGW      = PGW_DEF,
  parameter int unsigned CNTW     = CNTW_DEF,
  parameter int unsigned FIFO_LOG = FIFO_LOG_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic [2:0]      cmd_i,
  input  logic [PGW-1:0]  page_i,
  input  logic [CNTW-1:0] count_i,
  output logic            busy_o,
  output logic            cmplt_o,
  output logic [1:0]      err_o,
  output logic [CNTW-1:0] ndone_o,
  output logic            stat_o,
  input  logic            rd_i,
  output logic [PGW-1:0]  rdat_o,
  output logic            empty_o,
  output logic            pam_alloc_o,
  output logic            pam_free_o,
  output logic            pam_freeall_o,
  output logic            pam_stat_o,
  output logic [1:0]      pam_val_o,
  output logic [PGW-1:0]  pam_page_o,
  input  logic [PGW-1:0]  pam_page_i,
  input  logic            pam_done_i
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  cmd_t            cmd_q, cmd_nxt;
  logic [PGW-1:0]  page_q, page_nxt, res_q, res_nxt, ppage_nxt;
  logic [CNTW-1:0] cnt_q, cnt_nxt, ndone_nxt;
  logic [TW-1:0]   tmr_q, tmr_nxt;
  logic [1:0]      err_nxt, val_nxt;
  logic            busy_nxt, cmplt_nxt, stat_nxt;
  pam_strb_t       strb_q, strb_nxt;
  logic            push_c, flush_c, fifo_full;

  pam_req_fifo #(.W(PGW), .LOG(FIFO_LOG)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_c),
    .push  (push_c),
    .wdat  (res_q),
    .pop   (rd_i),
    .rdat  (rdat_o),
    .empty (empty_o),
    .full  (fifo_full)
  );

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    page_nxt  = page_q;
    cnt_nxt   = cnt_q;
    tmr_nxt   = tmr_q;
    res_nxt   = res_q;
    ndone_nxt = ndone_o;
    err_nxt   = err_o;
    stat_nxt  = stat_o;
    val_nxt   = pam_val_o;
    ppage_nxt = pam_page_o;
    strb_nxt  = '0;
    push_c    = 1'b0;
    flush_c   = 1'b0;

    unique case (state)
      ST_WAITRDY: if (pam_done_i) state_nxt = ST_IDLE;

      ST_IDLE: begin
        if (req_i) begin
          ndone_nxt = '0;
          err_nxt   = ERR_OK;
          stat_nxt  = 1'b0;
          page_nxt  = page_i;
          cnt_nxt   = (count_i == '0) ? CNTW'(1) : count_i;
          if (cmd_i <= 3'(CLR)) begin
            cmd_nxt   = cmd_t'(cmd_i);
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_FINISH;
          end
        end
      end

      // Allocation holds here while the FIFO has no room for the result.
      ST_ISSUE: begin
        tmr_nxt = '0;
        if (!(cmd_q == ALLOC_N && fifo_full)) begin
          state_nxt = ST_ACCEPT;
          ppage_nxt = (cmd_q == ALLOC_N) ? '0 : page_q;
          val_nxt   = VAL_READ;
          case (cmd_q)
            ALLOC_N: strb_nxt.alloc = 1'b1;
            FREE_N:  strb_nxt.free  = 1'b1;
            FREEALL: begin
              strb_nxt.freeall = 1'b1;
              flush_c          = 1'b1;
            end
            STAT:    strb_nxt.stat = 1'b1;
            SET: begin
              strb_nxt.stat = 1'b1;
              val_nxt       = VAL_SET;
            end
            CLR: begin
              strb_nxt.stat = 1'b1;
              val_nxt       = VAL_CLR;
            end
            default: ;
          endcase
        end
      end

      ST_ACCEPT: begin
        if (!pam_done_i) begin
          state_nxt = ST_WAIT;
          tmr_nxt   = tmr_q + TW'(1);
        end else if (tmr_q == TW'(TIMEOUT)) begin
          err_nxt   = ERR_TMO;
          state_nxt = ST_FINISH;
        end else begin
          tmr_nxt = tmr_q + TW'(1);
        end
      end

      ST_WAIT: begin
        if (pam_done_i) begin
          res_nxt   = pam_page_i;
          state_nxt = ST_NEXT;
        end else if (tmr_q == TW'(TIMEOUT)) begin
          err_nxt   = ERR_TMO;
          state_nxt = ST_FINISH;
        end else begin
          tmr_nxt = tmr_q + TW'(1);
        end
      end

      // Page 0 is never allocatable, so a zero result means the map is full.
      ST_NEXT: begin
        case (cmd_q)
          ALLOC_N: begin
            if (res_q == '0) begin
              err_nxt   = ERR_OOM;
              state_nxt = ST_FINISH;
            end else begin
              push_c    = 1'b1;
              ndone_nxt = ndone_o + CNTW'(1);
              state_nxt = (ndone_nxt == cnt_q) ? ST_FINISH : ST_ISSUE;
            end
          end
          FREE_N: begin
            ndone_nxt = ndone_o + CNTW'(1);
            page_nxt  = page_q + PGW'(1);
            state_nxt = (ndone_nxt == cnt_q) ? ST_FINISH : ST_ISSUE;
          end
          default: begin
            ndone_nxt = CNTW'(1);
            stat_nxt  = res_q[0];
            state_nxt = ST_FINISH;
          end
        endcase
      end

      ST_FINISH: state_nxt = ST_IDLE;

      default: state_nxt = ST_WAITRDY;
    endcase

    busy_nxt  = (state_nxt != ST_IDLE);
    cmplt_nxt = (state_nxt == ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAITRDY;
      cmd_q      <= ALLOC_N;
      page_q     <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      res_q      <= '0;
      busy_o     <= 1'b1;
      cmplt_o    <= 1'b0;
      err_o      <= ERR_OK;
      ndone_o    <= '0;
      stat_o     <= 1'b0;
      strb_q     <= '0;
      pam_val_o  <= '0;
      pam_page_o <= '0;
    end else begin
      state      <= state_nxt;
      cmd_q      <= cmd_nxt;
      page_q     <= page_nxt;
      cnt_q      <= cnt_nxt;
      tmr_q      <= tmr_nxt;
      res_q      <= res_nxt;
      busy_o     <= busy_nxt;
      cmplt_o    <= cmplt_nxt;
      err_o      <= err_nxt;
      ndone_o    <= ndone_nxt;
      stat_o     <= stat_nxt;
      strb_q     <= strb_nxt;
      pam_val_o  <= val_nxt;
      pam_page_o <= ppage_nxt;
    end
  end

  assign pam_alloc_o   = strb_q.alloc;
  assign pam_free_o    = strb_q.free;
  assign pam_freeall_o = strb_q.freeall;
  assign pam_stat_o    = strb_q.stat;

endmodule

// File: tb/tb_pam_requester.sv
// Bench for pam_requester: behavioural 512-page PAM plus completion and FIFO scoreboards.
module tb_pam_requester;
  import pam_pkg::*;

  localparam int unsigned PGW     = 15;
  localparam int unsigned CNTW    = 8;
  localparam int unsigned TIMEOUT = 1023;
  localparam int unsigned NPG     = 512;
  localparam int unsigned BIG     = 1000000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req_i = 1'b0;
  logic [2:0]      cmd_i = '0;
  logic [PGW-1:0]  page_i = '0;
  logic [CNTW-1:0] count_i = '0;
  logic            busy_o, cmplt_o, stat_o, empty_o;
  logic [1:0]      err_o, pam_val_o;
  logic [CNTW-1:0] ndone_o;
  logic            rd_i = 1'b0;
  logic [PGW-1:0]  rdat_o, pam_page_o;
  logic            pam_alloc_o, pam_free_o, pam_freeall_o, pam_stat_o;
  logic [PGW-1:0]  pam_page_i = '0;
  logic            pam_done_i = 1'b0;

  always #5 clk = ~clk;

  pam_requester dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .cmd_i(cmd_i), .page_i(page_i),
    .count_i(count_i), .busy_o(busy_o), .cmplt_o(cmplt_o), .err_o(err_o),
    .ndone_o(ndone_o), .stat_o(stat_o), .rd_i(rd_i), .rdat_o(rdat_o),
    .empty_o(empty_o), .pam_alloc_o(pam_alloc_o), .pam_free_o(pam_free_o),
    .pam_freeall_o(pam_freeall_o), .pam_stat_o(pam_stat_o), .pam_val_o(pam_val_o),
    .pam_page_o(pam_page_o), .pam_page_i(pam_page_i), .pam_done_i(pam_done_i)
  );

  // ---------------- PAM model ----------------
  logic [NPG-1:0] map = '0;
  int             init_ct = 40;
  int             busy_ct = 0;
  logic           hang = 1'b0;
  logic [1:0]     op_q = '0;
  logic [8:0]     op_pg = '0;
  logic [1:0]     op_val = '0;
  logic [8:0]     ff;

  function automatic logic [NPG-1:0] rsv_mask();
    logic [NPG-1:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[i] = 1'b1;
    m[NPG-1] = 1'b1;
    return m;
  endfunction

  function automatic logic [8:0] first_free(input logic [NPG-1:0] m);
    logic [8:0] r;
    r = '0;
    for (int i = NPG - 1; i >= 0; i--) if (!m[i]) r = 9'(i);
    return r;
  endfunction

  assign ff = first_free(map);

  always @(posedge clk) begin
    if (init_ct != 0) begin
      init_ct <= init_ct - 1;
      if (init_ct == 1) begin
        map        <= rsv_mask();
        pam_done_i <= 1'b1;
      end
    end else if (busy_ct != 0) begin
      busy_ct <= busy_ct - 1;
      if (busy_ct == 1) begin
        pam_done_i <= 1'b1;
        case (op_q)
          2'd0: begin
            pam_page_i <= PGW'(ff);
            if (ff != '0) map[ff] <= 1'b1;
          end
          2'd1: begin
            map[op_pg] <= 1'b0;
            pam_page_i <= '0;
          end
          2'd2: begin
            map        <= rsv_mask();
            pam_page_i <= '0;
          end
          default: begin
            pam_page_i <= PGW'(map[op_pg]);
            if (op_val == VAL_SET) map[op_pg] <= 1'b1;
            if (op_val == VAL_CLR) map[op_pg] <= 1'b0;
          end
        endcase
      end
    end else if (pam_done_i && !hang &&
                 (pam_alloc_o || pam_free_o || pam_freeall_o || pam_stat_o)) begin
      pam_done_i <= 1'b0;
      busy_ct    <= 2 + int'($urandom_range(0, 3));
      op_q       <= pam_alloc_o ? 2'd0 : pam_free_o ? 2'd1 : pam_freeall_o ? 2'd2 : 2'd3;
      op_pg      <= pam_page_o[8:0];
      op_val     <= pam_val_o;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  err;
    int unsigned ndone;
    logic        chk_stat;
    logic        stat;
  } cexp_t;

  cexp_t       cq[$];
  int unsigned pq[$];
  int          cmplt_cnt = 0;
  int          pop_left = 0;
  int          strb_cnt = 0;
  int          multi = 0;
  int          sn;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Completion scoreboard.
  initial forever begin
    cexp_t e;
    @(negedge clk);
    if (rst_n && cmplt_o) begin
      cmplt_cnt++;
      if (cq.size() == 0) check("cmplt_unexpected", 1, 0);
      else begin
        e = cq.pop_front();
        check({e.tag, "_err"}, 32'(err_o), 32'(e.err));
        check({e.tag, "_ndone"}, 32'(ndone_o), e.ndone);
        if (e.chk_stat) check({e.tag, "_stat"}, 32'(stat_o), 32'(e.stat));
      end
    end
  end

  // FIFO drain and page scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && pop_left > 0 && !empty_o) begin
      if (pq.size() == 0) check("fifo_extra", 1, 0);
      else check("fifo_page", 32'(rdat_o), pq.pop_front());
      pop_left--;
      rd_i = 1'b1;
    end else begin
      rd_i = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    sn = 32'(pam_alloc_o) + 32'(pam_free_o) + 32'(pam_freeall_o) + 32'(pam_stat_o);
    strb_cnt += sn;
    if (sn > 1) multi++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_o && k < 30000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 32'(busy_o), 0);
  endtask

  task automatic wait_empty(input string tag);
    int k = 0;
    while (!empty_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_empty"}, 32'(empty_o), 1);
  endtask

  task automatic issue(input cmd_t c, input int unsigned pg, input int unsigned cnt,
                       input string tag, input logic [1:0] err, input int unsigned nd,
                       input logic cs, input logic st);
    cexp_t e;
    wait_idle(tag);
    e.tag = tag; e.err = err; e.ndone = nd; e.chk_stat = cs; e.stat = st;
    cq.push_back(e);
    cmd_i   = 3'(c);
    page_i  = PGW'(pg);
    count_i = CNTW'(cnt);
    req_i   = 1'b1;
    @(negedge clk);
    req_i   = 1'b0;
  endtask

  task automatic wait_cmplt(input string tag, input int target);
    int k = 0;
    while (cmplt_cnt < target && k < 30000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_cmplt"}, 32'(cmplt_cnt >= target), 1);
  endtask

  task automatic run(input cmd_t c, input int unsigned pg, input int unsigned cnt,
                     input string tag, input logic [1:0] err, input int unsigned nd,
                     input logic cs, input logic st);
    int base;
    base = cmplt_cnt;
    issue(c, pg, cnt, tag, err, nd, cs, st);
    wait_cmplt(tag, base + 1);
  endtask

  task automatic exp_pages(input int unsigned first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) pq.push_back(first + i);
  endtask

  initial begin
    int base, s0, t0, k;
    #1 rst_n = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy_o), 1);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_cmplt", 32'(cmplt_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_ndone", 32'(ndone_o), 0);
    check("rst_strobes", 32'(strb_cnt), 0);
    rst_n = 1'b1;
    tick(5);
    check("waitrdy_busy", 32'(busy_o), 1);
    pop_left = BIG;

    // Basic allocation, free/realloc and status.
    exp_pages(32, 3);
    run(ALLOC_N, 0, 3, "alloc3", ERR_OK, 3, 1'b0, 1'b0);
    run(FREE_N, 33, 1, "free33", ERR_OK, 1, 1'b0, 1'b0);
    exp_pages(33, 1);
    run(ALLOC_N, 0, 1, "realloc", ERR_OK, 1, 1'b0, 1'b0);
    run(STAT, 33, 1, "stat33", ERR_OK, 1, 1'b1, 1'b1);
    run(FREE_N, 33, 2, "free33_2", ERR_OK, 2, 1'b0, 1'b0);

    // Exhaustion: 478 free pages (33..510).
    exp_pages(33, 255);
    run(ALLOC_N, 0, 255, "exh1", ERR_OK, 255, 1'b0, 1'b0);
    exp_pages(288, 223);
    run(ALLOC_N, 0, 255, "exh2", ERR_OOM, 223, 1'b0, 1'b0);
    wait_empty("exh");

    // Full-FIFO stall, and a request while busy must be dropped.
    run(FREE_N, 100, 30, "free100", ERR_OK, 30, 1'b0, 1'b0);
    pop_left = 0;
    exp_pages(100, 20);
    base = cmplt_cnt;
    issue(ALLOC_N, 0, 20, "alloc20", ERR_OK, 20, 1'b0, 1'b0);
    tick(300);
    check("stall_busy", 32'(busy_o), 1);
    check("stall_no_cmplt", 32'(cmplt_cnt), 32'(base));
    check("stall_not_empty", 32'(empty_o), 0);
    cmd_i = 3'(STAT); page_i = '0; req_i = 1'b1;
    tick(1);
    req_i = 1'b0;
    pop_left = 4;
    wait_cmplt("alloc20", base + 1);
    tick(20);
    check("busy_req_ignored", 32'(cmplt_cnt), 32'(base + 1));
    pop_left = BIG;
    wait_empty("alloc20");

    // Timeout when the PAM never accepts.
    hang = 1'b1;
    s0 = strb_cnt;
    base = cmplt_cnt;
    t0 = cyc;
    issue(ALLOC_N, 0, 1, "tmo", ERR_TMO, 0, 1'b0, 1'b0);
    wait_cmplt("tmo", base + 1);
    check("tmo_lat_min", 32'((cyc - t0) >= int'(TIMEOUT)), 1);
    check("tmo_lat_max", 32'((cyc - t0) <= int'(TIMEOUT) + 20), 1);
    tick(50);
    check("tmo_strobes", 32'(strb_cnt - s0), 1);
    hang = 1'b0;

    // Set/clear/stat on one page.
    run(FREE_N, 40, 1, "free40", ERR_OK, 1, 1'b0, 1'b0);
    run(SET, 40, 1, "set40", ERR_OK, 1, 1'b1, 1'b0);
    run(CLR, 40, 1, "clr40", ERR_OK, 1, 1'b1, 1'b1);
    run(STAT, 40, 1, "stat40", ERR_OK, 1, 1'b1, 1'b0);

    // FREEALL flushes buffered results.
    pop_left = 0;
    run(ALLOC_N, 0, 2, "alloc2", ERR_OK, 2, 1'b0, 1'b0);
    tick(2);
    check("pre_flush_empty", 32'(empty_o), 0);
    run(FREEALL, 0, 1, "freeall", ERR_OK, 1, 1'b1, 1'b0);
    check("flush_empty", 32'(empty_o), 1);

    // Asynchronous reset in the middle of an allocation.
    issue(ALLOC_N, 0, 5, "alloc_rst", ERR_OK, 5, 1'b0, 1'b0);
    k = 0;
    while (!pam_alloc_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_strobe_seen", 32'(pam_alloc_o), 1);
    #1 rst_n = 1'b0;
    void'(cq.pop_back());
    #1;
    check("rst_mid_strobes", 32'(pam_alloc_o) + 32'(pam_free_o) + 32'(pam_freeall_o) + 32'(pam_stat_o), 0);
    check("rst_mid_busy", 32'(busy_o), 1);
    check("rst_mid_empty", 32'(empty_o), 1);
    tick(2);
    rst_n = 1'b1;
    wait_idle("post_rst");
    run(STAT, 0, 1, "stat_rsv", ERR_OK, 1, 1'b1, 1'b1);

    tick(5);
    check("onehot_strobes", 32'(multi), 0);
    check("sb_leftover", 32'(cq.size() + pq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
